// File: rtl/wb_uart_rx_if.sv
// wb_uart_rx_if
//   Receive-side result bus between the UART receiver and the Wishbone-side
//   register/FIFO logic.
//
//   o_wr        : one-cycle strobe, o_data holds a freshly received byte
//   o_data      : last received byte, held until the next o_wr
//   o_frame_err : one-cycle strobe, stop bit was sampled low
//   o_busy      : receiver is inside a frame (start detected, not yet idle)
//
//   master : the receiver, drives every signal
//   slave  : the consumer, observes every signal
interface wb_uart_rx_if;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_frame_err;
  logic       o_busy;

  modport master (output o_wr, o_data, o_frame_err, o_busy);
  modport slave  (input  o_wr, o_data, o_frame_err, o_busy);
endinterface

// File: rtl/wb_uart_rx.sv
// wb_uart_rx
//   8N1 UART receiver. The asynchronous line is brought into i_clk through two
//   flops, the start bit is confirmed at mid-bit, then 8 data bits (LSB first)
//   and the stop bit are sampled at their centres. A good frame produces a
//   one-cycle o_wr with the byte on o_data; a low stop bit produces a
//   one-cycle o_frame_err and the receiver then waits for the line to go high.
//
//   Parameter CLOCKS_PER_BAUD : i_clk cycles per bit, must be >= 8.
//   i_clk      : system clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   i_uart_rx  : raw serial line, idle high, asynchronous to i_clk
//   bus        : result bus (o_wr, o_data, o_frame_err, o_busy), master side
//
//   Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes the
//   2-of-3 vote of the synchronized line one cycle before, at, and one cycle
//   after the bit centre. The decision is taken one cycle after the centre, so
//   all strobes arrive one cycle later than in the default build.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | line idle, waiting for a low level on the synchronized line
//   START  | counting to the middle of the start bit, then re-checking it
//   D0..D7 | counting to the centre of data bit n, then shifting it in
//   STOP   | counting to the centre of the stop bit, then strobing
//   BREAK  | stop bit was low; waiting for the line to return high
module wb_uart_rx #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_uart_rx,
  wb_uart_rx_if.master bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_D0    = 4'd2;
  localparam logic [3:0] S_D7    = 4'd9;
  localparam logic [3:0] S_STOP  = 4'd10;
  localparam logic [3:0] S_BREAK = 4'd11;

  localparam logic [23:0] HALF_M1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] FULL_M1 = CLOCKS_PER_BAUD - 24'd1;

  logic        r_q1;
  logic        r_ck_rx;
  logic [23:0] r_baud_cnt;
  logic [3:0]  r_state;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_wr;
  logic        r_frame_err;

  logic        w_tick;
  logic        w_timed;
  logic        w_decide;
  logic        w_sample;
  logic        w_data_state;

  // Two-flop synchronizer; idle level is high so reset to 1.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q1    <= 1'b1;
      r_ck_rx <= 1'b1;
    end else begin
      r_q1    <= i_uart_rx;
      r_ck_rx <= r_q1;
    end
  end

  assign w_tick       = (r_baud_cnt == 24'd0);
  // States that run the bit timer.
  assign w_timed      = (r_state != S_IDLE) && (r_state != S_BREAK);
  assign w_data_state = (r_state >= S_D0) && (r_state <= S_D7);

`ifdef UART_RX_MAJORITY_EN
  // r_hist[0] holds the line at the bit centre and r_hist[1] the cycle
  // before it when r_tick_d marks the cycle after the centre.
  logic [1:0] r_hist;
  logic       r_tick_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hist   <= 2'b11;
      r_tick_d <= 1'b0;
    end else begin
      r_hist   <= {r_hist[0], r_ck_rx};
      r_tick_d <= w_tick & w_timed;
    end
  end

  assign w_decide = r_tick_d;
  assign w_sample = (r_hist[1] & r_hist[0]) |
                    (r_hist[1] & r_ck_rx)   |
                    (r_hist[0] & r_ck_rx);
`else
  assign w_decide = w_tick & w_timed;
  assign w_sample = r_ck_rx;
`endif

  // Bit timer. Reload happens on the tick itself in both builds so the bit
  // grid is identical; with the vote only the decision is one cycle late.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_baud_cnt <= 24'd0;
    end else if (r_state == S_IDLE) begin
      if (!r_ck_rx) begin
        r_baud_cnt <= HALF_M1;
      end
    end else if (w_timed) begin
      if (w_tick) begin
        r_baud_cnt <= FULL_M1;
      end else begin
        r_baud_cnt <= r_baud_cnt - 24'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_wr        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr        <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == S_IDLE) begin
        if (!r_ck_rx) begin
          r_state <= S_START;
        end
      end else if (r_state == S_START) begin
        if (w_decide) begin
          // High at mid start bit means it was a glitch.
          r_state <= w_sample ? S_IDLE : S_D0;
        end
      end else if (w_data_state) begin
        if (w_decide) begin
          r_shift <= {w_sample, r_shift[7:1]};
          r_state <= r_state + 4'd1;
        end
      end else if (r_state == S_STOP) begin
        if (w_decide) begin
          // Leaving mid stop bit lets a following frame start with no idle.
          if (w_sample) begin
            r_data  <= r_shift;
            r_wr    <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= S_BREAK;
          end
        end
      end else if (r_state == S_BREAK) begin
        if (r_ck_rx) begin
          r_state <= S_IDLE;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign bus.o_wr        = r_wr;
  assign bus.o_data      = r_data;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_wb_uart_rx.sv
module tb_wb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  // Edges from T0 to the edge that raises a strobe.
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + EXTRA;

  logic clk = 1'b0;
  logic rst_n;
  logic rx = 1'b1;

  wb_uart_rx_if bus ();

  wb_uart_rx #(.CLOCKS_PER_BAUD(24'd16)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_uart_rx (rx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         wr_cnt = 0;
  int         err_cnt = 0;
  int         busy_cnt = 0;
  int         last_wr_cyc = 0;
  int         last_err_cyc = 0;
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  logic       both_hi = 1'b0;

  always @(negedge clk) begin
    if (bus.o_wr === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      wr_data.push_back(bus.o_data);
      wr_cyc.push_back(cyc);
    end
    if (bus.o_frame_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (bus.o_wr === 1'b1 && bus.o_frame_err === 1'b1) both_hi = 1'b1;
    if (bus.o_busy === 1'b1) busy_cnt++;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1 rx = b;
    repeat (CPB - 1) @(posedge clk);
  endtask

  // t0 is the cyc value of the first edge that samples the start bit low.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    @(posedge clk);
    #1 rx = 1'b0;
    t0 = cyc + 1;
    repeat (CPB - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_wr;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0, t1, w0, e0, b0, n;
    logic [7:0] part;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vecs[2] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{8'h7E, 1'b0, 0, 1, 8'h81};
    vecs[4] = '{8'h00, 1'b1, 1, 0, 8'h00};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr", 32'(bus.o_wr), 32'd0);
    check("rst_data", 32'(bus.o_data), 32'h00);
    check("rst_err", 32'(bus.o_frame_err), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    idle(100);
    #1;
    check("idle_wr", 32'(wr_cnt), 32'd0);
    check("idle_err", 32'(err_cnt), 32'd0);
    check("idle_busy", 32'(busy_cnt), 32'd0);
    check("idle_data", 32'(bus.o_data), 32'h00);

    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop, t0);
      #1 rx = 1'b1;
      idle(20);
      #1;
      check($sformatf("vec%0d_wr", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_data", i), 32'(bus.o_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy", i), 32'(bus.o_busy), 32'd0);
      if (vecs[i].exp_wr != 0)
        check($sformatf("vec%0d_lat", i), 32'(last_wr_cyc - t0), 32'(LAT));
      else
        check($sformatf("vec%0d_lat", i), 32'(last_err_cyc - t0), 32'(LAT));
    end

    // Back-to-back frames, no idle between stop and next start.
    w0 = wr_cnt;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    idle(20);
    #1;
    n = wr_data.size();
    check("b2b_count", 32'(wr_cnt - w0), 32'd2);
    check("b2b_data0", 32'(wr_data[n-2]), 32'h00);
    check("b2b_data1", 32'(wr_data[n-1]), 32'hFF);
    check("b2b_gap", 32'(wr_cyc[n-1] - wr_cyc[n-2]), 32'd160);
    check("b2b_lat", 32'(wr_cyc[n-2] - t0), 32'(LAT));

    // Short low glitch: rejected at mid start bit.
    w0 = wr_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    idle(30);
    #1;
    check("glitch_busy_len", 32'(busy_cnt - b0), 32'(8 + EXTRA));
    check("glitch_wr", 32'(wr_cnt - w0), 32'd0);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);

    // Framing error followed by a long break, then a good frame.
    w0 = wr_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0, t0);
    idle(300);
    #1;
    check("ferr_err", 32'(err_cnt - e0), 32'd1);
    check("ferr_wr", 32'(wr_cnt - w0), 32'd0);
    check("ferr_data", 32'(bus.o_data), 32'hFF);
    check("ferr_lat", 32'(last_err_cyc - t0), 32'(LAT));
    check("ferr_busy_break", 32'(bus.o_busy), 32'd1);
    rx = 1'b1;
    idle(10);
    #1;
    check("ferr_busy_release", 32'(bus.o_busy), 32'd0);
    send_frame(8'h11, 1'b1, t0);
    idle(20);
    #1;
    check("after_break_wr", 32'(wr_cnt - w0), 32'd1);
    check("after_break_data", 32'(bus.o_data), 32'h11);
    check("after_break_err", 32'(err_cnt - e0), 32'd1);

    // Reset while receiving bit 4 of a frame.
    w0 = wr_cnt;
    part = 8'h6B;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (CPB - 1) @(posedge clk);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    @(posedge clk);
    #1 rx = part[4];
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_data", 32'(bus.o_data), 32'h00);
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_wr", 32'(bus.o_wr), 32'd0);
    check("midrst_err", 32'(bus.o_frame_err), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    #1;
    check("midrst_no_strobe", 32'(wr_cnt - w0), 32'd0);
    send_frame(8'h5A, 1'b1, t0);
    idle(20);
    #1;
    check("post_rst_wr", 32'(wr_cnt - w0), 32'd1);
    check("post_rst_data", 32'(bus.o_data), 32'h5A);
    check("post_rst_lat", 32'(last_wr_cyc - t0), 32'(LAT));

    check("no_overlap", 32'(both_hi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
